// File: rtl/ifetch_pkg.sv
// Shared types and constants for the picoMIPS fetch stage and program counter.
package ifetch_pkg;

  localparam int P_SIZE_DEF = 6;
  localparam int I_SIZE_DEF = 16;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    HALT  = 2'd3
  } fetch_state_t;

  localparam logic [I_SIZE_DEF-1:0] HALT_WORD = {I_SIZE_DEF{1'b1}};

endpackage

// File: rtl/instruction_fetch.sv
// picoMIPS fetch stage: PC control, one-cycle ROM fetch, stall hold and branch flush.
// Optional halt-on-all-ones support is enabled with `define IFETCH_HALT_EN.
module instruction_fetch
  import ifetch_pkg::*;
#(
  parameter int P_SIZE = P_SIZE_DEF,
  parameter int I_SIZE = I_SIZE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [P_SIZE-1:0] pcAddress,
  input  logic [I_SIZE-1:0] romData,
  input  logic              stall,
  input  logic              branchReq,
  input  logic              branchIsRel,
  input  logic [P_SIZE-1:0] branchTarget,
  output logic              inc,
  output logic              branchAbs,
  output logic              branchRel,
  output logic [P_SIZE-1:0] branchAddress,
  output logic [I_SIZE-1:0] instr,
  output logic [P_SIZE-1:0] instrAddr,
  output logic              instrValid
);

  fetch_state_t      state_q, state_d;
  logic              stalled_q, stalled_d;
  logic [I_SIZE-1:0] hold_instr_q, hold_instr_d;
  logic [P_SIZE-1:0] hold_addr_q, hold_addr_d;
  logic [P_SIZE-1:0] addr_q, addr_d;

  logic [I_SIZE-1:0] cur_instr_s;
  logic [P_SIZE-1:0] cur_addr_s;
  logic              inc_s, abs_s, rel_s, valid_s;
  logic [P_SIZE-1:0] baddr_s;

  // After a stalled cycle the held word is shown instead of the ROM word.
  always_comb begin
    cur_instr_s = stalled_q ? hold_instr_q : romData;
    cur_addr_s  = stalled_q ? hold_addr_q  : addr_q;
  end

  always_comb begin
    state_d = state_q;
    inc_s   = 1'b0;
    abs_s   = 1'b0;
    rel_s   = 1'b0;
    baddr_s = '0;
    valid_s = 1'b0;
    case (state_q)
      FILL: begin
        inc_s   = 1'b1;
        state_d = RUN;
      end
      RUN: begin
        valid_s = 1'b1;
        if (stall) begin
          state_d = RUN;
`ifdef IFETCH_HALT_EN
        end else if (cur_instr_s == I_SIZE'(HALT_WORD)) begin
          state_d = HALT;
`endif
        end else if (branchReq) begin
          abs_s   = ~branchIsRel;
          rel_s   = branchIsRel;
          baddr_s = branchTarget;
          state_d = FLUSH;
        end else begin
          inc_s = 1'b1;
        end
      end
      FLUSH: begin
        inc_s   = 1'b1;
        state_d = RUN;
      end
`ifdef IFETCH_HALT_EN
      HALT: begin
        state_d = HALT;
      end
`endif
      default: begin
        state_d = FILL;
      end
    endcase
  end

  always_comb begin
    stalled_d    = (state_q == RUN) && stall;
    hold_instr_d = stalled_d ? cur_instr_s : hold_instr_q;
    hold_addr_d  = stalled_d ? cur_addr_s  : hold_addr_q;
    addr_d       = pcAddress;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= FILL;
      stalled_q    <= 1'b0;
      hold_instr_q <= '0;
      hold_addr_q  <= '0;
      addr_q       <= '0;
    end else begin
      state_q      <= state_d;
      stalled_q    <= stalled_d;
      hold_instr_q <= hold_instr_d;
      hold_addr_q  <= hold_addr_d;
      addr_q       <= addr_d;
    end
  end

  // romData is not cleared by our reset, so the data path is gated while rst is high.
  assign inc           = inc_s & ~rst;
  assign branchAbs     = abs_s;
  assign branchRel     = rel_s;
  assign branchAddress = baddr_s;
  assign instr         = rst ? '0 : cur_instr_s;
  assign instrAddr     = cur_addr_s;
  assign instrValid    = valid_s;

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch with a program-counter and registered-ROM model.
module tb_instruction_fetch;

  typedef struct packed {
    logic [5:0]  a;
    logic [15:0] d;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0, branchReq = 1'b0, branchIsRel = 1'b0;
  logic [5:0]  branchTarget = 6'd0;
  logic        inc, branchAbs, branchRel, instrValid;
  logic [5:0]  branchAddress, instrAddr;
  logic [15:0] instr;

  logic [5:0]  pc_q;
  logic [15:0] rom_q;
  logic [15:0] mem [0:63];

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail = 0;
  bit   sb_on = 1'b0;
  int   abs_cnt = 0, rel_cnt = 0, excl_err = 0, valid_cnt = 0;
  int   a0, r0, v0;

  always #5 clk = ~clk;

  instruction_fetch #(.P_SIZE(6), .I_SIZE(16)) dut (
    .clk(clk), .rst(rst), .pcAddress(pc_q), .romData(rom_q),
    .stall(stall), .branchReq(branchReq), .branchIsRel(branchIsRel),
    .branchTarget(branchTarget), .inc(inc), .branchAbs(branchAbs),
    .branchRel(branchRel), .branchAddress(branchAddress), .instr(instr),
    .instrAddr(instrAddr), .instrValid(instrValid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            pc_q <= 6'd0;
    else if (branchAbs) pc_q <= branchAddress;
    else if (branchRel) pc_q <= pc_q + branchAddress;
    else if (inc)       pc_q <= pc_q + 6'd1;
  end

  always_ff @(posedge clk) rom_q <= mem[pc_q];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per valid instruction.
  always @(negedge clk) begin
    exp_t e;
    if (int'(inc) + int'(branchAbs) + int'(branchRel) > 1) excl_err++;
    if (branchAbs === 1'b1) abs_cnt++;
    if (branchRel === 1'b1) rel_cnt++;
    if (instrValid === 1'b1) valid_cnt++;
    if (sb_on && instrValid === 1'b1) begin
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_unexpected: got addr %0d instr %h, required no output", instrAddr, instr);
      end else begin
        e = q.pop_front();
        chk("sb_addr", 32'(instrAddr), 32'(e.a));
        chk("sb_instr", 32'(instr), 32'(e.d));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      exp_t e;
      e.a = 6'(i % 64);
      e.d = 16'h1000 + 16'(i % 64);
      q.push_back(e);
    end
  endtask

  task automatic wait_addr(input logic [5:0] a);
    int k = 0;
    while (!(instrValid === 1'b1 && instrAddr == a) && k < 200) begin
      tick();
      k++;
    end
    n_tests++;
    if (k >= 200) begin
      n_fail++;
      $display("FAIL wait_addr: timeout, instrAddr %0d required %0d", instrAddr, a);
    end
  endtask

  task automatic wait_empty();
    int k = 0;
    while (q.size() != 0 && k < 300) begin
      tick();
      k++;
    end
    sb_on = 1'b0;
    chk("sb_drained", 32'(q.size()), 32'd0);
    q.delete();
  endtask

  task automatic do_reset();
    sb_on = 1'b0;
    stall = 1'b0;
    branchReq = 1'b0;
    branchIsRel = 1'b0;
    branchTarget = 6'd0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_inc"}, 32'(inc), 32'd0);
    chk({tag, "_abs"}, 32'(branchAbs), 32'd0);
    chk({tag, "_rel"}, 32'(branchRel), 32'd0);
    chk({tag, "_baddr"}, 32'(branchAddress), 32'd0);
    chk({tag, "_instr"}, 32'(instr), 32'd0);
    chk({tag, "_iaddr"}, 32'(instrAddr), 32'd0);
    chk({tag, "_valid"}, 32'(instrValid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 16'h1000 + 16'(i);
    tick();
    tick();
    chk_reset_vals("rst");

    // Free run with wrap-around 63 -> 0.
    rst = 1'b0;
    push_range(0, 69);
    sb_on = 1'b1;
    @(negedge clk);
    chk("fill_valid", 32'(instrValid), 32'd0);
    chk("fill_inc", 32'(inc), 32'd1);
    @(negedge clk);
    chk("first_valid", 32'(instrValid), 32'd1);
    wait_empty();

    // Asynchronous reset mid-run.
    #2;
    rst = 1'b1;
    #1;
    chk_reset_vals("midrst");
    tick();

    // Absolute branch to 5 on address 2.
    do_reset();
    push_range(0, 2);
    push_range(5, 7);
    sb_on = 1'b1;
    a0 = abs_cnt;
    wait_addr(6'd2);
    branchReq = 1'b1;
    branchIsRel = 1'b0;
    branchTarget = 6'd5;
    @(negedge clk);
    chk("abs_abs", 32'(branchAbs), 32'd1);
    chk("abs_rel", 32'(branchRel), 32'd0);
    chk("abs_inc", 32'(inc), 32'd0);
    chk("abs_baddr", 32'(branchAddress), 32'd5);
    tick();
    branchReq = 1'b0;
    @(negedge clk);
    chk("abs_bubble", 32'(instrValid), 32'd0);
    chk("abs_flush_inc", 32'(inc), 32'd1);
    chk("abs_baddr_clr", 32'(branchAddress), 32'd0);
    wait_empty();
    chk("abs_pulses", 32'(abs_cnt - a0), 32'd1);

    // Relative branch, offset 8, on address 4 -> 13.
    do_reset();
    push_range(0, 4);
    push_range(13, 15);
    sb_on = 1'b1;
    r0 = rel_cnt;
    wait_addr(6'd4);
    branchReq = 1'b1;
    branchIsRel = 1'b1;
    branchTarget = 6'd8;
    @(negedge clk);
    chk("rel_rel", 32'(branchRel), 32'd1);
    chk("rel_abs", 32'(branchAbs), 32'd0);
    chk("rel_baddr", 32'(branchAddress), 32'd8);
    tick();
    branchReq = 1'b0;
    @(negedge clk);
    chk("rel_bubble", 32'(instrValid), 32'd0);
    wait_empty();
    chk("rel_pulses", 32'(rel_cnt - r0), 32'd1);

    // Three-cycle stall on address 7, branch to 20 requested during the stall.
    do_reset();
    push_range(0, 7);
    push_range(7, 7);
    push_range(7, 7);
    push_range(7, 7);
    push_range(20, 21);
    sb_on = 1'b1;
    a0 = abs_cnt;
    wait_addr(6'd7);
    stall = 1'b1;
    @(negedge clk);
    chk("stall_inc", 32'(inc), 32'd0);
    tick();
    branchReq = 1'b1;
    branchIsRel = 1'b0;
    branchTarget = 6'd20;
    @(negedge clk);
    chk("stall_abs", 32'(branchAbs), 32'd0);
    chk("stall_inc2", 32'(inc), 32'd0);
    chk("stall_instr", 32'(instr), 32'h1007);
    tick();
    @(negedge clk);
    chk("stall_abs3", 32'(branchAbs), 32'd0);
    tick();
    stall = 1'b0;
    @(negedge clk);
    chk("release_abs", 32'(branchAbs), 32'd1);
    chk("release_instr", 32'(instr), 32'h1007);
    chk("release_addr", 32'(instrAddr), 32'd7);
    tick();
    branchReq = 1'b0;
    @(negedge clk);
    chk("release_bubble", 32'(instrValid), 32'd0);
    wait_empty();
    chk("stall_pulses", 32'(abs_cnt - a0), 32'd1);
    chk("exclusive_ctrl", 32'(excl_err), 32'd0);

`ifdef IFETCH_HALT_EN
    // All-ones word at address 9 halts the fetch.
    mem[9] = 16'hFFFF;
    do_reset();
    push_range(0, 8);
    q.push_back(exp_t'({6'd9, 16'hFFFF}));
    sb_on = 1'b1;
    wait_empty();
    v0 = valid_cnt;
    a0 = abs_cnt;
    branchReq = 1'b1;
    branchTarget = 6'd3;
    repeat (6) tick();
    branchReq = 1'b0;
    chk("halt_valid", 32'(valid_cnt - v0), 32'd0);
    chk("halt_inc", 32'(inc), 32'd0);
    chk("halt_branch", 32'(abs_cnt - a0), 32'd0);
    mem[9] = 16'h1009;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage of the picoMIPS core, between the program counter and the decoder. It drives the program counter's `inc`, `branchAbs`, `branchRel` and `branchAddress` controls, and takes the synchronous program-ROM read data. It presents one instruction per cycle with its address and a valid flag. It also handles downstream stalls and branch flushes.

## Interface
- `P_SIZE`, 6: program address width; matches the program counter.
- `I_SIZE`, 16: instruction width.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `pcAddress`  in  P_SIZE  current program counter `addressOut`. Also drives the ROM address externally.
- `romData`  in  I_SIZE  ROM read data, registered in the ROM: holds `mem[pcAddress]` of the previous cycle.
- `stall`  in  1  decoder not ready; hold the current instruction.
- `branchReq`  in  1  take a branch for the current valid instruction.
- `branchIsRel`  in  1  with `branchReq`: 1 = relative, 0 = absolute.
- `branchTarget`  in  P_SIZE  absolute target, or relative offset.
- `inc`  out  1  program counter increment.
- `branchAbs`  out  1  program counter absolute load.
- `branchRel`  out  1  program counter relative add.
- `branchAddress`  out  P_SIZE  equals `branchTarget` when a branch is issued, else 0.
- `instr`  out  I_SIZE  current instruction.
- `instrAddr`  out  P_SIZE  address of `instr`.
- `instrValid`  out  1  `instr` is a real, unflushed instruction.

## Operation
- FSM states: FILL, RUN, FLUSH, HALT. Reset state is FILL.
- FILL:
  - `inc`=1, `instrValid`=0.
  - Next state RUN.
- RUN, `stall`=1:
  - `inc`=0, no branch outputs asserted.
  - `instr`, `instrAddr` and `instrValid` held stable.
  - Stall has priority over `branchReq`; a request made during a stall is ignored and must be held by the requester.
- RUN, `stall`=0, `branchReq`=1:
  - `inc`=0.
  - `branchAbs`=!`branchIsRel`, `branchRel`=`branchIsRel`, `branchAddress`=`branchTarget`, all for exactly one cycle.
  - Next state FLUSH.
- RUN, `stall`=0, `branchReq`=0:
  - `inc`=1.
- FLUSH:
  - `inc`=1, `instrValid`=0; the wrong-path word is discarded.
  - Next state RUN.
- `branchReq` is ignored when `instrValid`=0.
- Relative target = `pcAddress` in the branch cycle (instruction address + 1) + offset, modulo 2^P_SIZE. This addition is done by the program counter.
- `instrAddr` = `pcAddress` registered one cycle earlier, under the same hold rule as `instr`.
- Wrap-around: address 2^P_SIZE−1 is followed by address 0. No special handling.
- `branchAbs`, `branchRel` and `inc` are never asserted together.

## Timing
- Reset values: `inc`=0, `branchAbs`=0, `branchRel`=0, `branchAddress`=0, `instr`=0, `instrAddr`=0, `instrValid`=0.
- Reset asserted mid-operation forces the reset values immediately, independent of the clock.
- First valid instruction: `mem[0]` appears in the second cycle after `rst` falls.
- Fetch latency: one cycle from `pcAddress` to `instr`.
- Throughput: one instruction per cycle.
- Branch penalty: exactly one bubble (the FLUSH cycle). The target instruction is valid two cycles after the branch cycle.
- Stall hold: the block keeps an internal hold register. `instr` comes from this register in every cycle following a stalled cycle, and from `romData` otherwise.
- Stall release: the held instruction is still presented in the release cycle. The next instruction follows one cycle later with no bubble.

## Configuration
- `IFETCH_HALT_EN` defined:
  - A valid `instr` equal to `HALT_WORD` (all ones) in RUN with `stall`=0 moves the FSM to HALT.
  - HALT: `inc`=0, `instrValid`=0, branch requests ignored, until `rst`.
- `IFETCH_HALT_EN` undefined:
  - The HALT state does not exist; all-ones is an ordinary instruction.

## Structure
- Package `ifetch_pkg` holds:
  - `fetch_state_t` enum {FILL, RUN, FLUSH, HALT}.
  - `HALT_WORD` constant.
  - Default `P_SIZE` and `I_SIZE` constants, shared with the program counter.
- Single module, no sub-module. The FSM, hold register and output mux stay in `instruction_fetch`.

## Test plan
All scenarios use `P_SIZE`=6, the real program counter, and a ROM model with `mem[i]`=16'h1000+i.
- Reset, then free run: first `instrValid`=1 in cycle 2 with `instr`=16'h1000 and `instrAddr`=0, then 16'h1001, 16'h1002 … consecutively.
- Run 70 cycles: `instrAddr` 63 → 0, with `instr` 16'h103F followed by 16'h1000.
- Absolute branch to 5 while `instr`=16'h1002: `branchAbs` pulses once, one cycle with `instrValid`=0, then `instr`=16'h1005.
- Relative branch, offset 8, on address 4: target 13, one bubble, then `instr`=16'h100D.
- 3-cycle `stall` on address 7, with `branchReq` raised during the stall:
  - `instr`=16'h1007 held for 4 cycles and no branch taken.
  - The branch is taken in the first unstalled cycle.
- `rst` asserted mid-run:
  - All outputs return to reset values immediately.
  - With `IFETCH_HALT_EN`, `mem[9]`=16'hFFFF halts the fetch after address 9 and `instrValid` stays 0.
